// File: rtl/slot_round_ctrl.sv
// rtl/slot_round_ctrl.sv - slot machine round sequencer: bet debit, reel freeze schedule, scoring, payout
// Optional macro REEL_SKIP_EN: spin_req during SPIN freezes the lowest-indexed running reel early.
module slot_round_ctrl #(
  parameter int BET          = 10,
  parameter int START_CREDIT = 100,
  parameter int MAX_SCORE    = 9999,
  parameter int FIRST_STOP   = 2,
  parameter int STOP_GAP     = 1,
  parameter int PAY_FOUR     = 500,
  parameter int PAY_THREE    = 50,
  parameter int PAY_TWO_PAIR = 20,
  parameter int PAY_PAIR     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        spin_req,
  input  logic [3:0]  reel0,
  input  logic [3:0]  reel1,
  input  logic [3:0]  reel2,
  input  logic [3:0]  reel3,
  output logic [3:0]  reel_stop,
  output logic        spinning,
  output logic [13:0] score,
  output logic        is_broke,
  output logic        payout_valid,
  output logic [13:0] last_win
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SPIN   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_EVAL   = 3'd3;
  localparam logic [2:0] S_PAYOUT = 3'd4;

  localparam logic [13:0] BET_C   = 14'(BET);
  localparam logic [13:0] START_C = 14'(START_CREDIT);
  localparam logic [13:0] MAX_C   = 14'(MAX_SCORE);
  localparam logic [14:0] MAX_W   = 15'(MAX_SCORE);

  localparam logic [7:0] STOP_AT [4] = '{
    8'(FIRST_STOP),
    8'(FIRST_STOP + STOP_GAP),
    8'(FIRST_STOP + 2 * STOP_GAP),
    8'(FIRST_STOP + 3 * STOP_GAP)
  };

  logic [2:0]       state_q, state_d;
  logic [7:0]       tick_cnt_q, tick_cnt_d;
  logic [3:0]       reel_stop_q, reel_stop_d;
  logic             spinning_q, spinning_d;
  logic [13:0]      score_q, score_d;
  logic             is_broke_q, is_broke_d;
  logic             payout_valid_q, payout_valid_d;
  logic [13:0]      last_win_q, last_win_d;
  logic [13:0]      win_q, win_d;
  logic [3:0][3:0]  sym_q, sym_d;

  logic [7:0]  tick_inc;
  logic [3:0]  sched;
  logic [3:0]  skip;
  logic [2:0]  n_eq;
  logic [14:0] sum_w;

  always_comb begin
    tick_inc = (tick_cnt_q == 8'hFF) ? 8'hFF : tick_cnt_q + 8'd1;
    for (int i = 0; i < 4; i++) begin
      sched[i] = tick && (tick_inc == STOP_AT[i]);
    end
`ifdef REEL_SKIP_EN
    // ~x & (x+1) isolates the lowest clear bit, i.e. the lowest running reel
    skip = spin_req ? (~reel_stop_q & (reel_stop_q + 4'd1)) : 4'b0000;
`else
    skip = 4'b0000;
`endif
  end

  // Number of equal symbol pairs uniquely identifies the hand: 6/3/2/1/0
  always_comb begin
    n_eq = {2'b00, sym_q[0] == sym_q[1]} + {2'b00, sym_q[0] == sym_q[2]}
         + {2'b00, sym_q[0] == sym_q[3]} + {2'b00, sym_q[1] == sym_q[2]}
         + {2'b00, sym_q[1] == sym_q[3]} + {2'b00, sym_q[2] == sym_q[3]};
    sum_w = {1'b0, score_q} + {1'b0, win_q};
  end

  always_comb begin
    state_d        = state_q;
    tick_cnt_d     = tick_cnt_q;
    reel_stop_d    = reel_stop_q;
    spinning_d     = spinning_q;
    score_d        = score_q;
    payout_valid_d = 1'b0;
    last_win_d     = last_win_q;
    win_d          = win_q;
    sym_d          = sym_q;

    case (state_q)
      S_IDLE: begin
        if (spin_req && (score_q >= BET_C)) begin
          score_d     = score_q - BET_C;
          reel_stop_d = 4'b0000;
          spinning_d  = 1'b1;
          tick_cnt_d  = 8'd0;
          state_d     = S_SPIN;
        end
      end
      S_SPIN: begin
        if (tick) begin
          tick_cnt_d = tick_inc;
        end
        reel_stop_d = reel_stop_q | sched | skip;
        if (&reel_stop_d) begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        sym_d   = {reel3, reel2, reel1, reel0};
        state_d = S_EVAL;
      end
      S_EVAL: begin
        case (n_eq)
          3'd6:    win_d = 14'(PAY_FOUR);
          3'd3:    win_d = 14'(PAY_THREE);
          3'd2:    win_d = 14'(PAY_TWO_PAIR);
          3'd1:    win_d = 14'(PAY_PAIR);
          default: win_d = 14'd0;
        endcase
        state_d = S_PAYOUT;
      end
      S_PAYOUT: begin
        score_d        = (sum_w > MAX_W) ? MAX_C : sum_w[13:0];
        last_win_d     = win_q;
        payout_valid_d = 1'b1;
        spinning_d     = 1'b0;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    is_broke_d = score_d < BET_C;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      tick_cnt_q     <= 8'd0;
      reel_stop_q    <= 4'b1111;
      spinning_q     <= 1'b0;
      score_q        <= START_C;
      is_broke_q     <= (START_C < BET_C);
      payout_valid_q <= 1'b0;
      last_win_q     <= 14'd0;
      win_q          <= 14'd0;
      sym_q          <= '0;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      reel_stop_q    <= reel_stop_d;
      spinning_q     <= spinning_d;
      score_q        <= score_d;
      is_broke_q     <= is_broke_d;
      payout_valid_q <= payout_valid_d;
      last_win_q     <= last_win_d;
      win_q          <= win_d;
      sym_q          <= sym_d;
    end
  end

  assign reel_stop    = reel_stop_q;
  assign spinning     = spinning_q;
  assign score        = score_q;
  assign is_broke     = is_broke_q;
  assign payout_valid = payout_valid_q;
  assign last_win     = last_win_q;

endmodule

// File: tb/tb_slot_round_ctrl.sv
// tb/tb_slot_round_ctrl.sv - self-checking bench for slot_round_ctrl
// Covers table rounds, reset, broke/saturation builds, early skip and random rounds.
module tb_slot_round_ctrl;

  localparam int BET        = 10;
  localparam int MAXS       = 9999;
  localparam int FIRST_STOP = 2;
  localparam int STOP_GAP   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tick, spin_req;
  logic [3:0] r0, r1, r2, r3;

  logic [3:0]  a_reel_stop, b_reel_stop, c_reel_stop;
  logic        a_spinning, b_spinning, c_spinning;
  logic [13:0] a_score, b_score, c_score;
  logic        a_is_broke, b_is_broke, c_is_broke;
  logic        a_pv, b_pv, c_pv;
  logic [13:0] a_last_win, b_last_win, c_last_win;

  slot_round_ctrl u_a (
    .clk(clk), .rst(rst), .tick(tick), .spin_req(spin_req),
    .reel0(r0), .reel1(r1), .reel2(r2), .reel3(r3),
    .reel_stop(a_reel_stop), .spinning(a_spinning), .score(a_score),
    .is_broke(a_is_broke), .payout_valid(a_pv), .last_win(a_last_win)
  );

  slot_round_ctrl #(.START_CREDIT(9)) u_b (
    .clk(clk), .rst(rst), .tick(tick), .spin_req(spin_req),
    .reel0(r0), .reel1(r1), .reel2(r2), .reel3(r3),
    .reel_stop(b_reel_stop), .spinning(b_spinning), .score(b_score),
    .is_broke(b_is_broke), .payout_valid(b_pv), .last_win(b_last_win)
  );

  slot_round_ctrl #(.START_CREDIT(10005)) u_c (
    .clk(clk), .rst(rst), .tick(tick), .spin_req(spin_req),
    .reel0(r0), .reel1(r1), .reel2(r2), .reel3(r3),
    .reel_stop(c_reel_stop), .spinning(c_spinning), .score(c_score),
    .is_broke(c_is_broke), .payout_valid(c_pv), .last_win(c_last_win)
  );

  int checks = 0;
  int failures = 0;
  int exp_score;

  typedef struct {
    int s0, s1, s2, s3;
    int win;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand rank from a symbol histogram
  function automatic int ref_win(input int s0, input int s1, input int s2, input int s3);
    int h [16];
    int n2, n3, n4;
    n2 = 0; n3 = 0; n4 = 0;
    for (int v = 0; v < 16; v++) h[v] = 0;
    h[s0]++; h[s1]++; h[s2]++; h[s3]++;
    for (int v = 0; v < 16; v++) begin
      if (h[v] == 2) n2++;
      if (h[v] == 3) n3++;
      if (h[v] == 4) n4++;
    end
    if (n4 > 0) return 500;
    if (n3 > 0) return 50;
    if (n2 == 2) return 20;
    if (n2 == 1) return 10;
    return 0;
  endfunction

  task automatic run_round(input int s0, input int s1, input int s2, input int s3,
                           input int exp_win, input int skip_n, input bit rnd);
    int ticks;
    int cyc;
    logic [3:0] fz;
    bit t, s, found;
    ticks = 0;
    fz = 4'b0000;
    r0 = 4'(s0); r1 = 4'(s1); r2 = 4'(s2); r3 = 4'(s3);
    spin_req = 1'b1;
    tick = 1'($urandom_range(0, 1));
    step();
    spin_req = 1'b0;
    tick = 1'b0;
    chk("launch_pv_low", 32'(a_pv), 0);
    if (exp_score < BET) begin
      chk("broke_score_hold", 32'(a_score), 32'(exp_score));
      chk("broke_reel_stop", 32'(a_reel_stop), 32'hF);
      chk("broke_spinning", 32'(a_spinning), 0);
      return;
    end
    exp_score -= BET;
    chk("debit_score", 32'(a_score), 32'(exp_score));
    chk("launch_reel_stop", 32'(a_reel_stop), 0);
    chk("launch_spinning", 32'(a_spinning), 1);
    chk("launch_is_broke", 32'(a_is_broke), 32'(exp_score < BET));

    for (int k = 0; k < skip_n; k++) begin
      spin_req = 1'b1;
      step();
      spin_req = 1'b0;
`ifdef REEL_SKIP_EN
      found = 1'b0;
      for (int i = 0; i < 4; i++) if (!found && !fz[i]) begin fz[i] = 1'b1; found = 1'b1; end
`endif
      chk("skip_reel_stop", 32'(a_reel_stop), 32'(fz));
    end
    if (skip_n == 2) begin
`ifdef REEL_SKIP_EN
      chk("skip_two_early", 32'(a_reel_stop), 32'h3);
`else
      chk("skip_two_ignored", 32'(a_reel_stop), 32'h0);
`endif
    end

    cyc = 0;
    while (fz != 4'hF && cyc < 300) begin
      t = rnd ? ($urandom_range(0, 2) == 0) : (cyc % 2 == 0);
      s = rnd && ($urandom_range(0, 7) == 0);
      tick = t;
      spin_req = s;
      step();
      cyc++;
      tick = 1'b0;
      spin_req = 1'b0;
`ifdef REEL_SKIP_EN
      if (s) begin
        found = 1'b0;
        for (int i = 0; i < 4; i++) if (!found && !fz[i]) begin fz[i] = 1'b1; found = 1'b1; end
      end
`endif
      if (t && ticks < 255) ticks++;
      for (int i = 0; i < 4; i++) if (ticks >= FIRST_STOP + i * STOP_GAP) fz[i] = 1'b1;
      chk("spin_reel_stop", 32'(a_reel_stop), 32'(fz));
      chk("spin_spinning", 32'(a_spinning), 1);
      chk("spin_pv_low", 32'(a_pv), 0);
    end
    if (fz != 4'hF) begin
      checks++;
      failures++;
      $display("FAIL freeze_timeout actual=%0d required=%0d", a_reel_stop, 15);
      return;
    end

    for (int k = 1; k <= 3; k++) begin
      tick = 1'($urandom_range(0, 1));
      spin_req = 1'($urandom_range(0, 1));
      step();
      tick = 1'b0;
      spin_req = 1'b0;
      // symbols were latched on the first edge after the final freeze
      r0 = 4'($urandom); r1 = 4'($urandom); r2 = 4'($urandom); r3 = 4'($urandom);
      if (k < 3) begin
        chk("settle_pv_low", 32'(a_pv), 0);
        chk("settle_spinning", 32'(a_spinning), 1);
        chk("settle_score", 32'(a_score), 32'(exp_score));
      end else begin
        exp_score = (exp_score + exp_win > MAXS) ? MAXS : exp_score + exp_win;
        chk("payout_pv", 32'(a_pv), 1);
        chk("payout_score", 32'(a_score), 32'(exp_score));
        chk("payout_last_win", 32'(a_last_win), 32'(exp_win));
        chk("payout_spinning", 32'(a_spinning), 0);
        chk("payout_reel_stop", 32'(a_reel_stop), 32'hF);
        chk("payout_is_broke", 32'(a_is_broke), 32'(exp_score < BET));
      end
    end
  endtask

  initial begin
    int s0, s1, s2, s3;
    vecs[0] = '{3, 3, 3, 3, 500};
    vecs[1] = '{1, 2, 1, 2, 20};
    vecs[2] = '{7, 7, 7, 0, 50};
    vecs[3] = '{0, 1, 2, 3, 0};
    vecs[4] = '{5, 9, 9, 5, 20};
    vecs[5] = '{4, 4, 2, 8, 10};
    vecs[6] = '{2, 9, 2, 2, 50};

    rst = 1'b1; tick = 1'b0; spin_req = 1'b0;
    r0 = 4'd0; r1 = 4'd0; r2 = 4'd0; r3 = 4'd0;
    step();
    step();
    chk("rst_score", 32'(a_score), 100);
    chk("rst_reel_stop", 32'(a_reel_stop), 32'hF);
    chk("rst_spinning", 32'(a_spinning), 0);
    chk("rst_is_broke", 32'(a_is_broke), 0);
    chk("rst_pv", 32'(a_pv), 0);
    chk("rst_last_win", 32'(a_last_win), 0);
    chk("rst_b_is_broke", 32'(b_is_broke), 1);
    chk("rst_c_score", 32'(c_score), 10005);
    rst = 1'b0;
    exp_score = 100;

    for (int v = 0; v < 7; v++) begin
      run_round(vecs[v].s0, vecs[v].s1, vecs[v].s2, vecs[v].s3, vecs[v].win, 0, 1'b0);
      if (v == 0) begin
        chk("b_no_launch_reel_stop", 32'(b_reel_stop), 32'hF);
        chk("b_no_launch_spinning", 32'(b_spinning), 0);
        chk("b_score_held", 32'(b_score), 9);
        chk("b_is_broke", 32'(b_is_broke), 1);
        chk("c_score_saturated", 32'(c_score), 9999);
        chk("c_last_win", 32'(c_last_win), 500);
      end
    end

    // Reset after reel 1 freezes
    r0 = 4'd6; r1 = 4'd6; r2 = 4'd6; r3 = 4'd6;
    spin_req = 1'b1;
    step();
    spin_req = 1'b0;
    tick = 1'b1;
    for (int k = 0; k < 3; k++) step();
    tick = 1'b0;
    chk("mid_reel_stop_pre", 32'(a_reel_stop), 32'h3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_score", 32'(a_score), 100);
    chk("mid_rst_reel_stop", 32'(a_reel_stop), 32'hF);
    chk("mid_rst_spinning", 32'(a_spinning), 0);
    chk("mid_rst_is_broke", 32'(a_is_broke), 0);
    chk("mid_rst_pv", 32'(a_pv), 0);
    chk("mid_rst_last_win", 32'(a_last_win), 0);
    exp_score = 100;

    run_round(1, 2, 1, 2, 20, 2, 1'b0);

    for (int n = 0; n < 25; n++) begin
      s0 = $urandom_range(0, 15);
      s1 = ($urandom_range(0, 2) == 0) ? s0 : $urandom_range(0, 15);
      s2 = ($urandom_range(0, 2) == 0) ? s1 : $urandom_range(0, 15);
      s3 = ($urandom_range(0, 2) == 0) ? s0 : $urandom_range(0, 15);
      run_round(s0, s1, s2, s3, ref_win(s0, s1, s2, s3), 0, 1'b1);
    end

    step();
    chk("final_pv_low", 32'(a_pv), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
